// File: rtl/outlier_stream_drain.sv
// Outlier stream drain: pops single positions from the outlier FIFO, packs two per
// AXI4-Stream beat and closes the cloud with a PAD-filled TLAST beat once the
// controller reports done and the FIFO has stayed empty long enough to be drained.
module outlier_stream_drain #(
  parameter int unsigned   N   = 16,
  parameter logic [N-1:0]  PAD = {N{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             done_in,
  input  logic             fifo_empty,
  input  logic [N-1:0]     fifo_dout,
  output logic             fifo_rd_en,
  output logic [2*N-1:0]   m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [N-1:0]     outlier_count,
  output logic [N-1:0]     beat_count,
  output logic             finished
);

  typedef enum logic [2:0] {
    StWait,
    StLatch,
    StSend,
    StClose,
    StLast,
    StDone
  } state_e;

  localparam logic [N-1:0] CountMax = {N{1'b1}};
  localparam logic [N-1:0] CountOne = {{(N-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             half_q, half_d;
  logic [N-1:0]     hold_q, hold_d;
  // Consecutive cycles with FIFO empty and done_in high.
  logic [1:0]       empty_done_cnt_q, empty_done_cnt_d;
  logic [2*N-1:0]   tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [N-1:0]     outlier_count_q, outlier_count_d;
  logic [N-1:0]     beat_count_q, beat_count_d;
  logic             finished_q, finished_d;

  // Read strobe: only one read in flight, since WAIT is left on every issued read.
  assign fifo_rd_en = (state_q == StWait) & ~fifo_empty & ~reset;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign outlier_count = outlier_count_q;
  assign beat_count    = beat_count_q;
  assign finished      = finished_q;

  // Next-state and next-output computation for the drain FSM.
  always_comb begin
    state_d          = state_q;
    half_d           = half_q;
    hold_d           = hold_q;
    empty_done_cnt_d = empty_done_cnt_q;
    tdata_d          = tdata_q;
    tvalid_d         = tvalid_q;
    tlast_d          = tlast_q;
    outlier_count_d  = outlier_count_q;
    beat_count_d     = beat_count_q;
    finished_d       = finished_q;

    case (state_q)
      StWait: begin
        if (!fifo_empty) begin
          state_d          = StLatch;
          empty_done_cnt_d = 2'd0;
        end else if (done_in) begin
          // Two empty cycles are needed: a write just before done may not yet show
          // up on fifo_empty.
          empty_done_cnt_d = empty_done_cnt_q + 2'd1;
          if (empty_done_cnt_q == 2'd1) begin
            state_d = StClose;
          end
        end else begin
          empty_done_cnt_d = 2'd0;
        end
      end

      StLatch: begin
        if (outlier_count_q != CountMax) begin
          outlier_count_d = outlier_count_q + CountOne;
        end
        if (!half_q) begin
          hold_d  = fifo_dout;
          half_d  = 1'b1;
          state_d = StWait;
        end else begin
          tdata_d  = {hold_q, fifo_dout};
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          half_d   = 1'b0;
          state_d  = StSend;
        end
      end

      StSend: begin
        if (m_axis_tready) begin
          tvalid_d     = 1'b0;
          beat_count_d = beat_count_q + CountOne;
          state_d      = StWait;
        end
      end

      StClose: begin
        tvalid_d = 1'b1;
        tlast_d  = 1'b1;
        // A lone leftover position goes in the upper half; otherwise pure terminator.
        tdata_d  = half_q ? {hold_q, PAD} : {PAD, PAD};
        half_d   = 1'b0;
        state_d  = StLast;
      end

      StLast: begin
        if (m_axis_tready) begin
          tvalid_d     = 1'b0;
          tlast_d      = 1'b0;
          beat_count_d = beat_count_q + CountOne;
          finished_d   = 1'b1;
          state_d      = StDone;
        end
      end

      StDone: begin
        state_d = StDone;
      end

      default: begin
        state_d = StWait;
      end
    endcase
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StWait;
      half_q           <= 1'b0;
      hold_q           <= '0;
      empty_done_cnt_q <= 2'd0;
      tdata_q          <= '0;
      tvalid_q         <= 1'b0;
      tlast_q          <= 1'b0;
      outlier_count_q  <= '0;
      beat_count_q     <= '0;
      finished_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      half_q           <= half_d;
      hold_q           <= hold_d;
      empty_done_cnt_q <= empty_done_cnt_d;
      tdata_q          <= tdata_d;
      tvalid_q         <= tvalid_d;
      tlast_q          <= tlast_d;
      outlier_count_q  <= outlier_count_d;
      beat_count_q     <= beat_count_d;
      finished_q       <= finished_d;
    end
  end

endmodule

// File: tb/tb_outlier_stream_drain.sv
// Bench for outlier_stream_drain: behavioural FIFO model feeding the DUT, a beat
// scoreboard filled as positions are pushed, table-driven clouds and hand sequences.
module tb_outlier_stream_drain;

  localparam int unsigned N = 16;
  localparam logic [N-1:0] PAD = 16'hFFFF;

  logic            clock;
  logic            reset;
  logic            done_in;
  logic            fifo_empty;
  logic [N-1:0]    fifo_dout;
  logic            fifo_rd_en;
  logic [2*N-1:0]  m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [N-1:0]    outlier_count;
  logic [N-1:0]    beat_count;
  logic            finished;

  outlier_stream_drain #(.N(N), .PAD(PAD)) dut (
    .clock         (clock),
    .reset         (reset),
    .done_in       (done_in),
    .fifo_empty    (fifo_empty),
    .fifo_dout     (fifo_dout),
    .fifo_rd_en    (fifo_rd_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .outlier_count (outlier_count),
    .beat_count    (beat_count),
    .finished      (finished)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    int unsigned        npos;
    logic [0:5][15:0]   pos;
    int unsigned        exp_outliers;
    int unsigned        exp_beats;
    logic               rand_ready;
  } vec_t;

  logic [15:0] fifo_q [$];
  beat_t       sb [$];
  logic        have_half;
  logic [15:0] half_v;
  logic        rand_ready;
  int          passed;
  int          total;
  vec_t        vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Push one position into the FIFO model and extend the expected beat stream.
  task automatic push_pos(input logic [15:0] p);
    fifo_q.push_back(p);
    fifo_empty = 1'b0;
    if (have_half) begin
      sb.push_back('{data: {half_v, p}, last: 1'b0});
      have_half = 1'b0;
    end else begin
      half_v    = p;
      have_half = 1'b1;
    end
  endtask

  task automatic close_sb();
    sb.push_back('{data: have_half ? {half_v, PAD} : {PAD, PAD}, last: 1'b1});
    have_half = 1'b0;
  endtask

  // One clock: monitor handshakes at negedge, then update the FIFO model after posedge.
  task automatic tick();
    logic  rd;
    beat_t e;
    @(negedge clock);
    rd = fifo_rd_en;
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got 0x%0h last=%0b expected no beat",
                 m_axis_tdata, m_axis_tlast);
      end else begin
        e = sb.pop_front();
        chk("beat_data", 64'(m_axis_tdata), 64'(e.data));
        chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
      end
    end
    @(posedge clock);
    #1;
    if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_models();
    fifo_q.delete();
    sb.delete();
    have_half  = 1'b0;
    half_v     = '0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    rand_ready = 1'b0;
    done_in    = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_models();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_until_finished(input int budget);
    int n;
    n = 0;
    while (!finished && n < budget) begin
      tick();
      n++;
    end
    chk("finish_within_budget", 64'(finished), 64'(1));
  endtask

  task automatic wait_tvalid(input int budget);
    int n;
    n = 0;
    while (!m_axis_tvalid && n < budget) begin
      tick();
      n++;
    end
    chk("tvalid_within_budget", 64'(m_axis_tvalid), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    passed = 0;
    total  = 0;

    vecs[0] = '{4, {16'h0003, 16'h0007, 16'h0010, 16'h0022, 16'h0000, 16'h0000}, 4, 3, 1'b0};
    vecs[1] = '{3, {16'h0001, 16'h0002, 16'h0005, 16'h0000, 16'h0000, 16'h0000}, 3, 2, 1'b0};
    vecs[2] = '{0, {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 0, 1, 1'b0};
    vecs[3] = '{1, {16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 1, 1, 1'b1};
    vecs[4] = '{2, {16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 2, 2, 1'b1};
    vecs[5] = '{5, {16'h0000, 16'h0001, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h0000}, 5, 3, 1'b1};
    vecs[6] = '{6, {16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600}, 6, 4, 1'b1};

    reset = 1'b1;
    clear_models();
    tick();
    tick();
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("reset_tlast", 64'(m_axis_tlast), 64'(0));
    chk("reset_tdata", 64'(m_axis_tdata), 64'(0));
    chk("reset_outliers", 64'(outlier_count), 64'(0));
    chk("reset_beats", 64'(beat_count), 64'(0));
    chk("reset_finished", 64'(finished), 64'(0));
    chk("reset_rd_en", 64'(fifo_rd_en), 64'(0));

    // Table-driven clouds: preload FIFO, raise done, drain to completion.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int i = 0; i < int'(vecs[v].npos); i++) push_pos(vecs[v].pos[i]);
      close_sb();
      done_in    = 1'b1;
      rand_ready = vecs[v].rand_ready;
      run_until_finished(300);
      rand_ready    = 1'b0;
      m_axis_tready = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("vec_outliers", 64'(outlier_count), 64'(vecs[v].exp_outliers));
      chk("vec_beats", 64'(beat_count), 64'(vecs[v].exp_beats));
      chk("vec_sb_drained", 64'(sb.size()), 64'(0));
      chk("vec_idle_after_done", 64'({m_axis_tvalid, finished}), 64'(2'b01));
    end

    // Zero outliers from reset release: terminator appears 3-4 cycles later.
    reset = 1'b1;
    clear_models();
    tick();
    tick();
    reset   = 1'b0;
    done_in = 1'b1;
    close_sb();
    lat = 0;
    while (!m_axis_tvalid && lat < 20) begin
      tick();
      lat++;
    end
    chk("zero_latency_ok", 64'((lat >= 3 && lat <= 4) ? 1 : 0), 64'(1));
    chk("zero_term_data", 64'(m_axis_tdata), 64'(32'hFFFFFFFF));
    run_until_finished(20);
    chk("zero_outliers", 64'(outlier_count), 64'(0));

    // Backpressure: beat held 10 cycles while the FIFO keeps filling.
    do_reset();
    push_pos(16'h0011);
    push_pos(16'h0022);
    m_axis_tready = 1'b0;
    wait_tvalid(20);
    push_pos(16'h0033);
    push_pos(16'h0044);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_stable", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata, fifo_rd_en}),
          64'({1'b1, 1'b0, 32'h00110022, 1'b0}));
    end
    m_axis_tready = 1'b1;
    tick();
    chk("stall_beat_done", 64'(beat_count), 64'(1));
    close_sb();
    done_in = 1'b1;
    run_until_finished(100);
    chk("stall_outliers", 64'(outlier_count), 64'(4));
    chk("stall_beats", 64'(beat_count), 64'(3));

    // Single-cycle done pulses must not accumulate toward close.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      done_in = k[0] ? 1'b0 : 1'b1;
      tick();
      chk("done_pulse_no_close", 64'(m_axis_tvalid), 64'(0));
    end

    // done_in rises together with the final entry becoming visible.
    do_reset();
    for (int k = 0; k < 4; k++) tick();
    push_pos(16'h0009);
    done_in = 1'b1;
    close_sb();
    run_until_finished(50);
    chk("simul_outliers", 64'(outlier_count), 64'(1));
    chk("simul_beats", 64'(beat_count), 64'(1));

    // Entry appears one cycle after done with FIFO empty: still inside the window.
    do_reset();
    done_in = 1'b1;
    tick();
    push_pos(16'h0009);
    close_sb();
    run_until_finished(50);
    chk("late_entry_outliers", 64'(outlier_count), 64'(1));
    chk("late_entry_sb", 64'(sb.size()), 64'(0));

    // Reset while a beat is stalled in SEND, then a fresh run.
    do_reset();
    push_pos(16'h0100);
    push_pos(16'h0200);
    m_axis_tready = 1'b0;
    wait_tvalid(20);
    chk("pre_reset_outliers", 64'(outlier_count), 64'(2));
    reset = 1'b1;
    tick();
    chk("midsend_reset", 64'({m_axis_tvalid, m_axis_tlast, finished}), 64'(0));
    chk("midsend_counts", 64'({outlier_count, beat_count}), 64'(0));
    clear_models();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push_pos(vecs[0].pos[i]);
    close_sb();
    done_in = 1'b1;
    run_until_finished(100);
    chk("rerun_outliers", 64'(outlier_count), 64'(4));
    chk("rerun_beats", 64'(beat_count), 64'(3));
    chk("rerun_sb", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
